sdram_write: RTL and testbench

Write-path command sequencer for the single-bank SDRAM controller; the write-side counterpart of the read sequencer.
- Requests the bus from the controller arbiter and opens each row with ACT.
- Issues 4-beat WR bursts, pulling one data word per beat from an upstream first-word-fall-through source.
- Closes rows with PRE (auto-precharge-all), yields to refresh at burst boundaries, and resumes where it stopped.
- Fills rows 0..ROW_NUM-1, columns 0..511, bank 0.

---
 rtl/sdram_cmd_pkg.sv | 30 +++
 rtl/sdram_write.sv | 167 ++++++++++++++++
 tb/tb_sdram_write.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_pkg.sv
// Command encodings, sequencer states and address constants shared by the
// SDRAM read sequencer, write sequencer and bus arbiter.
package sdram_cmd_pkg;

    // {CSn, RASn, CASn, WEn}
    typedef enum logic [3:0] {
        CMD_NOP  = 4'b0111,
        CMD_ACT  = 4'b0011,
        CMD_RD   = 4'b0101,
        CMD_WR   = 4'b0100,
        CMD_PRE  = 4'b0010,
        CMD_AREF = 4'b0001
    } sdram_cmd_e;

    // One-hot sequencer states
    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_REQ  = 5'b00010,
        ST_ACT  = 5'b00100,
        ST_WR   = 5'b01000,
        ST_PRE  = 5'b10000
    } seq_state_e;

    // A10 high during PRE selects precharge-all
    localparam logic [11:0] A10_PRECHARGE_ALL = 12'h400;

    // Burst index of the last 4-beat burst in a 512-column row (col 508)
    localparam logic [6:0] LAST_BURST_IN_ROW = 7'd127;

endpackage

// File: rtl/sdram_write.sv
// Write-path command sequencer: requests the bus, opens rows with ACT,
// issues 4-beat WR bursts fed from a first-word-fall-through source,
// closes rows with PRE and yields to refresh only at burst boundaries.
module sdram_write
    import sdram_cmd_pkg::*;
#(
    parameter int unsigned ROW_NUM = 2,
    parameter int unsigned T_RCD   = 3,
    parameter int unsigned T_RP    = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        ref_req,
    output logic        wr_req,
    output logic        flag_wr_end,
    output logic        wr_done,
    output logic [3:0]  wr_cmd,
    output logic [11:0] wr_addr,
    output logic [1:0]  bank_addr,
    output logic        wr_dat_req,
    input  logic [15:0] wr_din,
    output logic [15:0] sd_wr_data
);

    localparam logic [3:0]  ACT_LAST = 4'(T_RCD - 1);
    localparam logic [3:0]  PRE_LAST = 4'(T_RP - 1);
    localparam logic [11:0] ROW_LAST = 12'(ROW_NUM - 1);

    seq_state_e  state_q;
    logic [11:0] row_q;
    logic [6:0]  burst_q;
    logic [1:0]  beat_q;
    logic [3:0]  act_cnt_q;
    logic [3:0]  pre_cnt_q;
    logic        done_q;
    logic        ref_pend_q;

    logic row_end;
    logic last_burst;

    assign row_end    = (burst_q == LAST_BURST_IN_ROW);
    assign last_burst = row_end && (row_q == ROW_LAST);

    assign wr_req     = (state_q == ST_REQ);
    assign wr_dat_req = (state_q == ST_WR);
    assign bank_addr  = 2'b00;

    // Sequencer FSM, address/beat counters and registered command outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            act_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            done_q      <= 1'b0;
            ref_pend_q  <= 1'b0;
            wr_cmd      <= CMD_NOP;
            wr_addr     <= '0;
            sd_wr_data  <= '0;
            flag_wr_end <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            wr_cmd      <= CMD_NOP;
            flag_wr_end <= 1'b0;
            wr_done     <= 1'b0;

            if (wr_dat_req) begin
                sd_wr_data <= wr_din;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (wr_trig) begin
                        state_q    <= ST_REQ;
                        row_q      <= '0;
                        burst_q    <= '0;
                        beat_q     <= '0;
                        done_q     <= 1'b0;
                        ref_pend_q <= 1'b0;
                    end
                end

                ST_REQ: begin
                    if (wr_en) begin
                        state_q   <= ST_ACT;
                        act_cnt_q <= '0;
                    end
                end

                ST_ACT: begin
                    wr_addr <= row_q;
                    if (act_cnt_q == '0) begin
                        wr_cmd <= CMD_ACT;
                    end
                    if (act_cnt_q == ACT_LAST) begin
                        state_q   <= ST_WR;
                        act_cnt_q <= '0;
                        beat_q    <= '0;
                    end else begin
                        act_cnt_q <= act_cnt_q + 4'd1;
                    end
                end

                ST_WR: begin
                    wr_addr <= {3'b000, burst_q, beat_q};
                    if (beat_q == 2'd0) begin
                        wr_cmd <= CMD_WR;
                    end
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        // The burst counter advances on every non-final burst end,
                        // including refresh yields, so the write resumes at the next
                        // unwritten burst; at row end it wraps 127->0 by itself.
                        if (last_burst) begin
                            state_q   <= ST_PRE;
                            done_q    <= 1'b1;
                            pre_cnt_q <= '0;
                        end else begin
                            burst_q <= burst_q + 7'd1;
                            if (row_end || ref_req) begin
                                state_q    <= ST_PRE;
                                pre_cnt_q  <= '0;
                                ref_pend_q <= ref_req;
                            end
                            if (row_end) begin
                                row_q <= row_q + 12'd1;
                            end
                        end
                    end
                end

                ST_PRE: begin
                    wr_addr <= A10_PRECHARGE_ALL;
                    if (pre_cnt_q == '0) begin
                        wr_cmd <= CMD_PRE;
                    end
                    if (pre_cnt_q == PRE_LAST) begin
                        pre_cnt_q  <= '0;
                        ref_pend_q <= 1'b0;
                        if (done_q) begin
                            state_q     <= ST_IDLE;
                            flag_wr_end <= 1'b1;
                            wr_done     <= 1'b1;
                        end else if (ref_pend_q || ref_req) begin
                            state_q     <= ST_REQ;
                            flag_wr_end <= 1'b1;
                        end else begin
                            state_q   <= ST_ACT;
                            act_cnt_q <= '0;
                        end
                    end else begin
                        pre_cnt_q <= pre_cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Directed self-checking bench for the SDRAM write sequencer.
module tb_sdram_write;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_trig = 1'b0;
    logic        wr_en = 1'b0;
    logic        ref_req = 1'b0;
    logic        wr_req;
    logic        flag_wr_end;
    logic        wr_done;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  bank_addr;
    logic        wr_dat_req;
    logic [15:0] wr_din;
    logic [15:0] sd_wr_data;

    sdram_write #(.ROW_NUM(2), .T_RCD(3), .T_RP(3)) dut (
        .CLK(CLK), .RST(RST), .wr_trig(wr_trig), .wr_en(wr_en), .ref_req(ref_req),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_done(wr_done),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .bank_addr(bank_addr),
        .wr_dat_req(wr_dat_req), .wr_din(wr_din), .sd_wr_data(sd_wr_data)
    );

    always #5 CLK = ~CLK;

    // Incrementing first-word-fall-through data source
    logic [15:0] src_q;
    logic        src_clr = 1'b1;
    always @(posedge CLK) begin
        if (src_clr) src_q <= '0;
        else if (wr_dat_req) src_q <= src_q + 16'd1;
    end
    assign wr_din = src_q;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc, exp_k, n_req, n_act, n_pre, n_flag, n_done;
    logic        sb_en = 1'b0;
    logic        prev_req = 1'b0;
    logic [11:0] act_row = '0;
    int unsigned act_log [8];
    int unsigned pre_log [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and update the scoreboard
    task automatic step();
        logic [3:0] ecmd;
        @(posedge CLK);
        #1;
        cyc++;
        if (wr_dat_req) n_req++;
        if (sb_en && prev_req) begin
            ecmd = ((exp_k % 4) == 0) ? C_WR : C_NOP;
            chk("beat", {act_row, wr_cmd, wr_addr, sd_wr_data},
                {12'(exp_k / 512), ecmd, 3'b000, 9'(exp_k % 512), 16'(exp_k)});
            exp_k++;
        end
        prev_req = wr_dat_req;
        if (wr_cmd === C_ACT) begin
            act_row = wr_addr;
            if (n_act < 8) begin
                act_log[n_act] = int'(wr_addr);
                pre_log[n_act] = n_pre;
            end
            n_act++;
        end
        if (wr_cmd === C_PRE) begin
            n_pre++;
            chk("pre_addr", 64'(wr_addr), 64'h400);
        end
        if (flag_wr_end) n_flag++;
        if (wr_done) n_done++;
    endtask

    // Trigger a fresh run and grant the bus two cycles later; grant stays high
    task automatic start_run();
        src_clr = 1'b1;
        step();
        src_clr = 1'b0;
        exp_k = 0; n_req = 0; n_act = 0; n_pre = 0; n_flag = 0; n_done = 0;
        prev_req = 1'b0;
        sb_en = 1'b1;
        cyc = 0;
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        chk("req_after_trig", 64'(wr_req), 64'd1);
        step();
        wr_en = 1'b1;
        step();
        chk("nop_at_grant", 64'(wr_cmd), 64'(C_NOP));
    endtask

    // ACT, NOP, NOP, WR with the given addresses
    task automatic act_seq(input string tag, input logic [11:0] row, input logic [11:0] col);
        step(); chk({tag, "_act"}, {wr_cmd, wr_addr}, {C_ACT, row});
        step(); chk({tag, "_nop1"}, 64'(wr_cmd), 64'(C_NOP));
        step(); chk({tag, "_nop2"}, 64'(wr_cmd), 64'(C_NOP));
        step(); chk({tag, "_wr"}, {wr_cmd, wr_addr}, {C_WR, col});
    endtask

    task automatic wait_wr(input string tag, input logic [11:0] col);
        int unsigned guard = 0;
        while (!(wr_cmd === C_WR && wr_addr === col) && guard < 2000) begin
            step();
            guard++;
        end
        chk({tag, "_wr_found"}, {wr_cmd, wr_addr}, {C_WR, col});
    endtask

    task automatic run_to_done(input string tag);
        int unsigned guard = 0;
        while (wr_done !== 1'b1 && guard < 3000) begin
            step();
            guard++;
        end
        chk({tag, "_done"}, {wr_done, flag_wr_end}, 2'b11);
    endtask

    initial begin
        // ---- reset values
        step();
        step();
        chk("rst_outputs", {wr_cmd, wr_addr, sd_wr_data, wr_req, wr_dat_req, flag_wr_end, wr_done},
            {C_NOP, 12'h000, 16'h0000, 4'b0000});
        chk("rst_bank", 64'(bank_addr), 64'd0);
        RST = 1'b0;

        // ---- reset asserted on beat 2 of the first burst
        start_run();
        wr_en = 1'b0;
        act_seq("rstA", 12'd0, 12'd0);
        step();
        sb_en = 1'b0;
        RST = 1'b1;
        #1;
        chk("rstA_async", {wr_cmd, wr_addr, sd_wr_data, wr_dat_req}, {C_NOP, 12'h000, 16'h0000, 1'b0});
        step();
        chk("rstA_held", {wr_cmd, wr_dat_req, wr_req, sd_wr_data}, {C_NOP, 2'b00, 16'h0000});
        RST = 1'b0;
        step();
        chk("rstA_idle", {wr_cmd, wr_req, wr_dat_req}, {C_NOP, 2'b00});

        // ---- undisturbed full run
        start_run();
        wr_en = 1'b0;
        act_seq("runB", 12'd0, 12'd0);
        run_to_done("runB");
        chk("runB_cycles", 64'(cyc), 64'd1039);
        chk("runB_beats", {32'(n_req), 32'(exp_k)}, {32'd1024, 32'd1024});
        chk("runB_acts", {32'(n_act), 32'(n_pre)}, {32'd2, 32'd2});
        chk("runB_act_rows", {32'(act_log[0]), 32'(act_log[1])}, {32'd0, 32'd1});
        chk("runB_pre_before_row1", 64'(pre_log[1]), 64'd1);
        chk("runB_flags", {32'(n_flag), 32'(n_done)}, {32'd1, 32'd1});
        step();
        chk("runB_pulse_end", {flag_wr_end, wr_done, wr_req, wr_cmd}, {3'b000, C_NOP});

        // ---- refresh request on beat 1 of the col-8 burst
        start_run();
        wr_en = 1'b0;
        act_seq("refC", 12'd0, 12'd0);
        wait_wr("refC", 12'd8);
        ref_req = 1'b1;
        step();
        step();
        step();
        chk("refC_last_beat", {wr_addr, wr_dat_req}, {12'd11, 1'b0});
        step();
        chk("refC_pre", 64'(wr_cmd), 64'(C_PRE));
        step();
        chk("refC_pre_nop", 64'(wr_cmd), 64'(C_NOP));
        step();
        chk("refC_yield", {flag_wr_end, wr_req, wr_done}, 3'b110);
        ref_req = 1'b0;
        step();
        chk("refC_wait_grant", {flag_wr_end, wr_req}, 2'b01);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        act_seq("refC_resume", 12'd0, 12'd12);
        run_to_done("refC");
        chk("refC_beats", {32'(n_req), 32'(exp_k)}, {32'd1024, 32'd1024});
        chk("refC_acts", {32'(n_act), 32'(n_pre)}, {32'd3, 32'd3});
        chk("refC_act_rows", {act_log[0][11:0], act_log[1][11:0], act_log[2][11:0]}, {12'd0, 12'd0, 12'd1});
        chk("refC_flags", {32'(n_flag), 32'(n_done)}, {32'd2, 32'd1});

        // ---- refresh request coinciding with row end
        start_run();
        wr_en = 1'b0;
        act_seq("refD", 12'd0, 12'd0);
        wait_wr("refD", 12'd508);
        ref_req = 1'b1;
        step();
        step();
        step();
        chk("refD_last_beat", {wr_addr, wr_dat_req}, {12'd511, 1'b0});
        step();
        step();
        step();
        chk("refD_yield", {flag_wr_end, wr_req, wr_done}, 3'b110);
        chk("refD_single_pre", 64'(n_pre), 64'd1);
        ref_req = 1'b0;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        act_seq("refD_row1", 12'd1, 12'd0);
        run_to_done("refD");
        chk("refD_beats", {32'(n_req), 32'(exp_k)}, {32'd1024, 32'd1024});
        chk("refD_acts", {32'(n_act), 32'(n_pre)}, {32'd2, 32'd2});
        chk("refD_flags", {32'(n_flag), 32'(n_done)}, {32'd2, 32'd1});

        // ---- stray wr_en during ACT and wr_trig during WR
        start_run();
        act_seq("strayE", 12'd0, 12'd0);
        wr_en = 1'b0;
        wait_wr("strayE", 12'd100);
        wr_trig = 1'b1;
        step();
        step();
        wr_trig = 1'b0;
        run_to_done("strayE");
        chk("strayE_cycles", 64'(cyc), 64'd1039);
        chk("strayE_beats", {32'(n_req), 32'(exp_k)}, {32'd1024, 32'd1024});
        chk("strayE_acts", {32'(n_act), 32'(n_pre)}, {32'd2, 32'd2});
        chk("strayE_flags", {32'(n_flag), 32'(n_done)}, {32'd1, 32'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
